// File: rtl/xs3_pkg.sv
// Shared types and constants for the sequential binary to BCD/excess-3 converter.
package xs3_pkg;

    localparam int unsigned DIGIT_W = 4;

    localparam logic [3:0] XS3_BIAS      = 4'd3;
    localparam logic [3:0] DABBLE_THRESH = 4'd5;

    localparam logic MODE_BCD = 1'b0;
    localparam logic MODE_XS3 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/dabble_digit.sv
// One BCD digit correction step of shift-add-3: digits of 5 or more get +3
// so that the following left shift carries correctly into the next digit.
module dabble_digit
    import xs3_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit_c
);

    assign o_digit_c = (i_digit >= DABBLE_THRESH) ? DIGIT_W'(i_digit + XS3_BIAS) : i_digit;

endmodule

// File: rtl/bin_to_xs3_seq.sv
// Bit-serial binary to packed BCD / excess-3 converter (double dabble), one input
// bit per clock, valid/ready on both sides, sticky overflow for undersized DIGITS.
module bin_to_xs3_seq
    import xs3_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [BIN_W-1:0]          in_bin,
    input  logic                      in_mode,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DIGIT_W*DIGITS-1:0] out_digits,
    output logic                      out_ovf
);

    localparam int unsigned DIG_W = DIGIT_W * DIGITS;
    localparam int unsigned CAT_W = DIG_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [BIN_W-1:0]   r_bin;
    logic [DIG_W-1:0]   r_digits;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_mode;
    logic               r_ovf;

    logic               r_in_ready;
    logic               r_out_valid;
    logic [DIG_W-1:0]   r_out_digits;
    logic               r_out_ovf;

    logic [DIG_W-1:0]   w_adj;
    logic [CAT_W-1:0]   w_cat_sh;
    logic [DIG_W-1:0]   w_dig_nxt;
    logic [BIN_W-1:0]   w_bin_nxt;
    logic               w_ovf_bit;
    logic [DIG_W-1:0]   w_enc;

    // Per-digit add-3 correction ahead of the shift
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_dabble
        dabble_digit u_dabble (
            .i_digit   (r_digits[g*DIGIT_W +: DIGIT_W]),
            .o_digit_c (w_adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // {digits,bin} << 1; the bit leaving the top digit is the overflow carry
    assign w_cat_sh  = {w_adj[DIG_W-2:0], r_bin, 1'b0};
    assign w_dig_nxt = w_cat_sh[CAT_W-1 -: DIG_W];
    assign w_bin_nxt = w_cat_sh[BIN_W-1:0];
    assign w_ovf_bit = w_adj[DIG_W-1];

    // Output encoding only; the dabble arithmetic always runs in plain BCD
    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_enc
        assign w_enc[g*DIGIT_W +: DIGIT_W] = (r_mode == MODE_XS3)
            ? DIGIT_W'(w_dig_nxt[g*DIGIT_W +: DIGIT_W] + XS3_BIAS)
            : w_dig_nxt[g*DIGIT_W +: DIGIT_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (in_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin        <= '0;
            r_digits     <= '0;
            r_cnt        <= '0;
            r_mode       <= MODE_BCD;
            r_ovf        <= 1'b0;
            r_in_ready   <= 1'b1;
            r_out_valid  <= 1'b0;
            r_out_digits <= '0;
            r_out_ovf    <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == IDLE);
            r_out_valid <= (w_state_nxt == DONE);
            if (w_accept) begin
                r_bin    <= in_bin;
                r_mode   <= in_mode;
                r_digits <= '0;
                r_ovf    <= 1'b0;
                r_cnt    <= CNT_W'(BIN_W);
            end else if (r_state == SHIFT) begin
                r_bin    <= w_bin_nxt;
                r_digits <= w_dig_nxt;
                r_ovf    <= r_ovf | w_ovf_bit;
                r_cnt    <= r_cnt - CNT_W'(1);
            end
            // Result captured on the final shift so it is ready with out_valid
            if (w_last) begin
                r_out_digits <= w_enc;
                r_out_ovf    <= r_ovf | w_ovf_bit;
            end
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_digits = r_out_digits;
    assign out_ovf    = r_out_ovf;

endmodule

// File: tb/tb_bin_to_xs3_seq.sv
// Self-checking bench: a 3-digit and a 2-digit converter driven in lockstep and
// compared against a decimal arithmetic reference model.
module tb_bin_to_xs3_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_bin;
    logic        in_mode;
    logic        out_ready;

    logic        ir_a, ov_a, of_a;
    logic [11:0] dg_a;
    logic        ir_b, ov_b, of_b;
    logic [7:0]  dg_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    bin_to_xs3_seq #(.BIN_W(8), .DIGITS(3)) u_dut_a (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (ir_a),
        .in_bin     (in_bin),
        .in_mode    (in_mode),
        .out_valid  (ov_a),
        .out_ready  (out_ready),
        .out_digits (dg_a),
        .out_ovf    (of_a)
    );

    bin_to_xs3_seq #(.BIN_W(8), .DIGITS(2)) u_dut_b (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (ir_b),
        .in_bin     (in_bin),
        .in_mode    (in_mode),
        .out_valid  (ov_b),
        .out_ready  (out_ready),
        .out_digits (dg_b),
        .out_ovf    (of_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Decimal digits of v, least significant first, optionally biased by 3
    function automatic logic [31:0] ref_enc(input int unsigned v, input logic mode, input int unsigned nd);
        logic [31:0] r;
        int unsigned p;
        int unsigned d;
        r = '0;
        p = v;
        for (int unsigned i = 0; i < nd; i++) begin
            d = p % 10;
            p = p / 10;
            if (mode) d = d + 3;
            r = r | (32'(d) << (4 * i));
        end
        return r;
    endfunction

    function automatic logic ref_ovf(input int unsigned v, input int unsigned nd);
        int unsigned lim;
        lim = 1;
        for (int unsigned i = 0; i < nd; i++) lim = lim * 10;
        return v >= lim;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_result(input int unsigned v, input logic mode);
        chk("digits_a", 32'(dg_a), ref_enc(v, mode, 3));
        chk("ovf_a",    32'(of_a), 32'(ref_ovf(v, 3)));
        chk("valid_b",  32'(ov_b), 32'd1);
        chk("digits_b", 32'(dg_b), ref_enc(v, mode, 2));
        chk("ovf_b",    32'(of_b), 32'(ref_ovf(v, 2)));
    endtask

    task automatic convert(input int unsigned v, input logic mode, input int unsigned hold);
        int unsigned n;
        n = 0;
        while (!ir_a && n < 50) begin
            step();
            n++;
        end
        chk("wait_ready", 32'(ir_a), 32'd1);
        in_valid = 1'b1;
        in_bin   = 8'(v);
        in_mode  = mode;
        step();
        in_valid = 1'b0;
        in_bin   = 8'($urandom);
        in_mode  = 1'($urandom);
        n = 0;
        while (!ov_a && n < 50) begin
            step();
            n++;
        end
        chk("latency", 32'(n), 32'd8);
        check_result(v, mode);
        for (int unsigned h = 0; h < hold; h++) begin
            step();
            chk("hold_valid", 32'(ov_a), 32'd1);
            chk("hold_digits", 32'(dg_a), ref_enc(v, mode, 3));
            chk("hold_ready", 32'(ir_a), 32'd0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("drop_valid", 32'(ov_a), 32'd0);
        chk("back_idle", 32'(ir_a), 32'd1);
    endtask

    initial begin
        int unsigned n;
        int          prev_acc;
        int          acc;
        logic        m;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_bin    = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        chk("rst_in_ready",  32'(ir_a), 32'd1);
        chk("rst_out_valid", 32'(ov_a), 32'd0);
        chk("rst_digits",    32'(dg_a), 32'd0);
        chk("rst_ovf",       32'(of_a), 32'd0);
        rst = 1'b0;
        step();

        convert(255, 1'b0, 0);
        chk("c255_bcd", 32'(dg_a), 32'h255);
        convert(255, 1'b1, 0);
        chk("c255_xs3", 32'(dg_a), 32'h588);
        convert(0,   1'b1, 0);
        chk("c0_xs3",   32'(dg_a), 32'h333);
        convert(9,   1'b1, 0);
        chk("c9_xs3",   32'(dg_a), 32'h33C);
        convert(200, 1'b0, 0);
        chk("c200_b",   32'(dg_b), 32'h00);
        chk("c200_bovf", 32'(of_b), 32'd1);
        convert(99,  1'b0, 0);
        chk("c99_b",    32'(dg_b), 32'h99);
        convert(123, 1'b1, 5);

        // Reset during the fourth shift cycle
        in_valid = 1'b1;
        in_bin   = 8'd200;
        in_mode  = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("midrst_valid_a", 32'(ov_a), 32'd0);
        chk("midrst_ready_a", 32'(ir_a), 32'd1);
        chk("midrst_ready_b", 32'(ir_b), 32'd1);
        step();
        rst = 1'b0;
        step();
        convert(37, 1'b0, 0);
        chk("c37_after_rst", 32'(dg_a), 32'h037);

        for (int i = 0; i < 30; i++) begin
            convert($urandom_range(0, 255), 1'($urandom), $urandom_range(0, 3));
        end

        // Back-to-back stream with garbage on in_bin during conversions
        out_ready = 1'b1;
        in_valid  = 1'b1;
        prev_acc  = -1;
        for (int v = 0; v < 256; v++) begin
            n = 0;
            while (!ir_a && n < 50) begin
                step();
                n++;
            end
            chk("stream_ready", 32'(ir_a), 32'd1);
            m       = 1'($urandom);
            in_bin  = 8'(v);
            in_mode = m;
            step();
            acc = cyc;
            if (prev_acc >= 0) chk("stream_period", 32'(acc - prev_acc), 32'd10);
            prev_acc = acc;
            in_bin  = 8'($urandom);
            in_mode = 1'($urandom);
            n = 0;
            while (!ov_a && n < 50) begin
                step();
                n++;
            end
            chk("stream_latency", 32'(n), 32'd8);
            check_result(32'(v), m);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
